// File: rtl/soc_top_pkg.sv
// Shared ISA constants and ALU helpers for the soc_top RV32I-subset core.
// Imported by the CPU, datapath and register file.
package soc_top_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_UIMM, WB_PC_UIMM, WB_LINK
    } wb_sel_e;

    // Shifts use only the low five bits of the second operand.
    function automatic logic [31:0] alu_eval(input alu_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/soc_top_if.sv
// Fetch/next-PC link between the CPU shell (PC + program ROM) and the
// single-cycle datapath.
interface soc_top_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;

    modport master (output pc, output instr, input next_pc);
    modport slave  (input pc, input instr, output next_pc);
endinterface

// File: rtl/soc_top_cpu.sv
// CPU shell: PC register, word-addressed program ROM with combinational
// fetch, and the single-cycle datapath.
module soc_top_cpu
    import soc_top_pkg::*;
#(
    parameter int          PROG_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(PROG_WORDS)-1:0] load_addr,
    input  logic [31:0]                   load_data
);

    localparam int IDX_W = $clog2(PROG_WORDS);

    reg [31:0]   program_memory [PROG_WORDS];
    logic [31:0] pc_reg;

    soc_top_if core_bus ();

    // Program memory is deliberately excluded from reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            program_memory[load_addr] <= load_data;
        end
    end

    assign core_bus.pc    = pc_reg;
    assign core_bus.instr = program_memory[pc_reg[IDX_W+1:2]];

    always_ff @(posedge clk) begin
        if (!reset) pc_reg <= RESET_PC;
        else        pc_reg <= core_bus.next_pc;
    end

    soc_top_single_instr single_instr (
        .clk   (clk),
        .reset (reset),
        .bus   (core_bus.slave)
    );

endmodule

// File: rtl/soc_top_reg_mem.sv
// 32x32 register file: two combinational read ports, one write port.
// x0 always reads zero and ignores writes.
module soc_top_reg_mem
    import soc_top_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0][4:0] raddr,
    output logic [1:0][31:0] rdata,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [31:0]     wdata
);

    reg [31:0] memory [32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                memory[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            memory[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            assign rdata[gi] = (raddr[gi] == 5'd0) ? 32'd0 : memory[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/soc_top_single_instr.sv
// Single-cycle datapath: decode, ALU, branch compare, write-back select and
// next-PC. Owns the register file.
module soc_top_single_instr
    import soc_top_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    soc_top_if.slave  bus
);

    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm_i;
    logic [31:0]      imm_u;
    logic [31:0]      imm_b;
    logic [31:0]      off_j;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic [31:0]      pc_plus4;
    alu_op_e          alu_op;
    logic [31:0]      alu_b;
    logic [31:0]      alu_y;
    wb_sel_e          wb_sel;
    logic             wb_en;
    logic [31:0]      wb_data;
    logic             branch_taken;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_u = {bus.instr[31:12], 12'b0};
    assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
    // JAL carries a plain two's-complement byte offset, not the scrambled J-imm.
    assign off_j = {{12{bus.instr[31]}}, bus.instr[31:12]};

    assign raddr    = {rs2, rs1};
    assign rs1_val  = rdata[0];
    assign rs2_val  = rdata[1];
    assign pc_plus4 = bus.pc + 32'd4;

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = (rs1_val == rs2_val);
            F3_BNE:  branch_taken = (rs1_val != rs2_val);
            F3_BLT:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: branch_taken = (rs1_val <  rs2_val);
            F3_BGEU: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Unrecognised encodings fall through with wb_en low and PC+4.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_b       = rs2_val;
        wb_sel      = WB_ALU;
        wb_en       = 1'b0;
        bus.next_pc = pc_plus4;
        case (opcode)
            OPC_OP_IMM: begin
                alu_b = imm_i;
                wb_en = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    F3_SLL: begin
                        if (funct7 == F7_BASE) alu_op = ALU_SLL;
                        else                   wb_en  = 1'b0;
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                        else                       wb_en  = 1'b0;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            OPC_OP: begin
                wb_en = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
                    {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
                    {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
                    {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
                    {F7_BASE, F3_OR}:   alu_op = ALU_OR;
                    {F7_BASE, F3_AND}:  alu_op = ALU_AND;
                    default:            wb_en  = 1'b0;
                endcase
            end
            OPC_LUI: begin
                wb_sel = WB_UIMM;
                wb_en  = 1'b1;
            end
            OPC_AUIPC: begin
                wb_sel = WB_PC_UIMM;
                wb_en  = 1'b1;
            end
            OPC_JAL: begin
                wb_sel      = WB_LINK;
                wb_en       = 1'b1;
                bus.next_pc = bus.pc + off_j;
            end
            OPC_JALR: begin
                // Target uses the pre-write rs1, so rd==rs1 links correctly.
                if (funct3 == 3'b000) begin
                    wb_sel      = WB_LINK;
                    wb_en       = 1'b1;
                    bus.next_pc = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken) bus.next_pc = bus.pc + imm_b;
            end
            default: ;
        endcase
    end

    assign alu_y = alu_eval(alu_op, rs1_val, alu_b);

    always_comb begin
        case (wb_sel)
            WB_UIMM:    wb_data = imm_u;
            WB_PC_UIMM: wb_data = bus.pc + imm_u;
            WB_LINK:    wb_data = pc_plus4;
            default:    wb_data = alu_y;
        endcase
    end

    soc_top_reg_mem reg_mem (
        .clk   (clk),
        .reset (reset),
        .raddr (raddr),
        .rdata (rdata),
        .we    (wb_en),
        .waddr (rd),
        .wdata (wb_data)
    );

endmodule

// File: rtl/soc_top.sv
// System top: one single-cycle RV32I-subset CPU with a private program ROM.
// No external bus; the ROM has no loader on this SoC and is filled in place.
module soc_top
    import soc_top_pkg::*;
#(
    parameter int          PROG_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic clk,
    input  logic reset
);

    soc_top_cpu #(
        .PROG_WORDS (PROG_WORDS),
        .RESET_PC   (RESET_PC)
    ) cpu (
        .clk       (clk),
        .reset     (reset),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_data ('0)
    );

endmodule

// File: tb/tb_soc_top.sv
// Self-checking bench for soc_top: directed instruction table, reset corner
// cases, and random programs against an ISA-level reference model.
module tb_soc_top;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ins;
        int          rd;
        logic [31:0] val;
        logic [31:0] npc;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [256];
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    vec_t        vecs [$];

    soc_top #(.PROG_WORDS(256), .RESET_PC(32'd0)) dut (
        .clk   (clk),
        .reset (reset)
    );

    soc_top_if mon ();
    assign mon.pc      = dut.cpu.pc_reg;
    assign mon.instr   = dut.cpu.core_bus.instr;
    assign mon.next_pc = dut.cpu.core_bus.next_pc;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1,
                                          input logic [2:0] f3);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int off, input int rd);
        return {off[19:0], rd[4:0], 7'b1101111};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.cpu.program_memory[i] = prog[i];
    endtask

    function automatic logic [31:0] dut_reg(input int r);
        return dut.cpu.single_instr.reg_mem.memory[r];
    endfunction

    task automatic add_vec(input string name, input logic [31:0] pc, input logic [31:0] ins,
                           input int rd, input logic [31:0] val, input logic [31:0] npc);
        vec_t v;
        v.name = name; v.pc = pc; v.ins = ins; v.rd = rd; v.val = val; v.npc = npc;
        vecs.push_back(v);
    endtask

    // ---------------- ISA-level reference model ----------------
    task automatic model_step(output int wr_rd);
        logic [31:0] ins, x, y, res, nxt;
        int          simm, boff, sx, sy;
        bit          wr;
        ins  = prog[m_pc[9:2]];
        x    = m_regs[ins[19:15]];
        y    = m_regs[ins[24:20]];
        sx   = int'(x);
        sy   = int'(y);
        simm = int'($signed(ins[31:20]));
        boff = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
             + int'(ins[11:8]) * 2;
        nxt  = m_pc + 32'd4;
        res  = 32'd0;
        wr   = 1'b0;
        case (ins[6:0])
            7'h13: begin
                wr = 1'b1;
                case (ins[14:12])
                    3'd0: res = x + 32'(simm);
                    3'd2: res = (sx < simm) ? 32'd1 : 32'd0;
                    3'd3: res = (x < 32'(simm)) ? 32'd1 : 32'd0;
                    3'd4: res = x ^ 32'(simm);
                    3'd6: res = x | 32'(simm);
                    3'd7: res = x & 32'(simm);
                    3'd1: if (ins[31:25] == 7'h00) res = x << ins[24:20]; else wr = 1'b0;
                    default: begin
                        if (ins[31:25] == 7'h00)      res = x >> ins[24:20];
                        else if (ins[31:25] == 7'h20) res = 32'(sx >>> ins[24:20]);
                        else                          wr = 1'b0;
                    end
                endcase
            end
            7'h33: begin
                wr = 1'b1;
                if (ins[31:25] == 7'h00) begin
                    case (ins[14:12])
                        3'd0: res = x + y;
                        3'd1: res = x << y[4:0];
                        3'd2: res = (sx < sy) ? 32'd1 : 32'd0;
                        3'd3: res = (x < y) ? 32'd1 : 32'd0;
                        3'd4: res = x ^ y;
                        3'd5: res = x >> y[4:0];
                        3'd6: res = x | y;
                        default: res = x & y;
                    endcase
                end else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin
                    res = x - y;
                end else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd5) begin
                    res = 32'(sx >>> y[4:0]);
                end else begin
                    wr = 1'b0;
                end
            end
            7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
            7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h000}; end
            7'h6F: begin
                wr  = 1'b1;
                res = m_pc + 32'd4;
                nxt = m_pc + 32'(int'($signed(ins[31:12])));
            end
            7'h67: begin
                if (ins[14:12] == 3'd0) begin
                    wr  = 1'b1;
                    res = m_pc + 32'd4;
                    nxt = (x + 32'(simm)) & 32'hFFFF_FFFE;
                end
            end
            7'h63: begin
                bit t;
                case (ins[14:12])
                    3'd0: t = (x == y);
                    3'd1: t = (x != y);
                    3'd4: t = (sx < sy);
                    3'd5: t = (sx >= sy);
                    3'd6: t = (x < y);
                    3'd7: t = (x >= y);
                    default: t = 1'b0;
                endcase
                if (t) nxt = m_pc + 32'(boff);
            end
            default: ;
        endcase
        wr_rd = 0;
        if (wr && ins[11:7] != 5'd0) begin
            m_regs[ins[11:7]] = res;
            wr_rd = int'(ins[11:7]);
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr();
        int          k, rd, rs1, rs2, off;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        k   = int'($urandom_range(0, 99));
        rd  = int'($urandom_range(0, 7));
        rs1 = int'($urandom_range(0, 7));
        rs2 = int'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        w   = $urandom();
        case ($urandom_range(0, 19))
            0:       f7 = 7'($urandom_range(0, 127));
            1, 2, 3: f7 = 7'h20;
            default: f7 = 7'h00;
        endcase
        if (k < 30) begin
            if (f3 == 3'd1 || f3 == 3'd5) w = enc_i(int'({f7, 5'(w[4:0])}), rs1, f3, rd, 7'h13);
            else                          w = enc_i(int'(w[11:0]), rs1, f3, rd, 7'h13);
        end else if (k < 55) begin
            w = enc_r(f7, rs2, rs1, f3, rd);
        end else if (k < 62) begin
            w = enc_u(int'(w[19:0]), rd, 7'h37);
        end else if (k < 68) begin
            w = enc_u(int'(w[19:0]), rd, 7'h17);
        end else if (k < 78) begin
            off = (int'($urandom_range(0, 16)) - 8) * 4;
            w = enc_b(off, rs2, rs1, f3);
        end else if (k < 86) begin
            off = (int'($urandom_range(0, 40)) - 20) * 2;
            w = enc_j(off, rd);
        end else if (k < 92) begin
            w = enc_i(int'(w[11:0]), rs1, (f3 < 3'd6) ? 3'd0 : f3, rd, 7'h67);
        end
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int wr_rd;
        int bad0;

        // Directed program: executed in table order starting from PC 0.
        add_vec("addi x5,x0,100",  32'd0,   enc_i(100, 0, 3'd0, 5, 7'h13),    5, 32'd100,      32'd4);
        add_vec("jal x1,+12",      32'd4,   enc_j(12, 1),                     1, 32'd8,        32'd16);
        add_vec("addi x5,x0,203",  32'd16,  enc_i(203, 0, 3'd0, 5, 7'h13),    5, 32'd203,      32'd20);
        add_vec("jal x2,-12",      32'd20,  enc_j(-12, 2),                    2, 32'd24,       32'd8);
        add_vec("addi x5,x0,200",  32'd8,   enc_i(200, 0, 3'd0, 5, 7'h13),    5, 32'd200,      32'd12);
        add_vec("jal x0,+12",      32'd12,  enc_j(12, 0),                     0, 32'd0,        32'd24);
        add_vec("beq x0,x0,+8",    32'd24,  enc_b(8, 0, 0, 3'd0),             0, 32'd0,        32'd32);
        add_vec("bne x0,x0,+8",    32'd32,  enc_b(8, 0, 0, 3'd1),             0, 32'd0,        32'd36);
        add_vec("addi x0,x0,5",    32'd36,  enc_i(5, 0, 3'd0, 0, 7'h13),      0, 32'd0,        32'd40);
        add_vec("lui x3,0x80000",  32'd40,  enc_u(32'h80000, 3, 7'h37),       3, 32'h80000000, 32'd44);
        add_vec("addi x3,x3,-1",   32'd44,  enc_i(-1, 3, 3'd0, 3, 7'h13),     3, 32'h7FFFFFFF, 32'd48);
        add_vec("addi x4,x0,1",    32'd48,  enc_i(1, 0, 3'd0, 4, 7'h13),      4, 32'd1,        32'd52);
        add_vec("add x3,x3,x4",    32'd52,  enc_r(7'h00, 4, 3, 3'd0, 3),      3, 32'h80000000, 32'd56);
        add_vec("sub x6,x0,x4",    32'd56,  enc_r(7'h20, 4, 0, 3'd0, 6),      6, 32'hFFFFFFFF, 32'd60);
        add_vec("srai x7,x3,4",    32'd60,  enc_i(32'h404, 3, 3'd5, 7, 7'h13),7, 32'hF8000000, 32'd64);
        add_vec("srli x8,x3,4",    32'd64,  enc_i(4, 3, 3'd5, 8, 7'h13),      8, 32'h08000000, 32'd68);
        add_vec("slt x9,x3,x4",    32'd68,  enc_r(7'h00, 4, 3, 3'd2, 9),      9, 32'd1,        32'd72);
        add_vec("sltu x10,x3,x4",  32'd72,  enc_r(7'h00, 4, 3, 3'd3, 10),    10, 32'd0,        32'd76);
        add_vec("auipc x11,1",     32'd76,  enc_u(1, 11, 7'h17),             11, 32'h0000104C, 32'd80);
        add_vec("blt x3,x4,+8",    32'd80,  enc_b(8, 4, 3, 3'd4),             0, 32'd0,        32'd88);
        add_vec("bgeu x3,x4,+8",   32'd88,  enc_b(8, 4, 3, 3'd7),             0, 32'd0,        32'd96);
        add_vec("jalr x4,x4,104",  32'd96,  enc_i(104, 4, 3'd0, 4, 7'h67),    4, 32'd100,      32'd104);
        add_vec("slli x12,x4,3",   32'd104, enc_i(3, 4, 3'd1, 12, 7'h13),    12, 32'd800,      32'd108);
        add_vec("xori x13,x12,-1", 32'd108, enc_i(-1, 12, 3'd4, 13, 7'h13),  13, 32'hFFFFFCDF, 32'd112);
        add_vec("illegal word",    32'd112, 32'hFFFFFFFF,                    31, 32'd0,        32'd116);
        add_vec("srl x14,x6,x4",   32'd116, enc_r(7'h00, 4, 6, 3'd5, 14),    14, 32'h0FFFFFFF, 32'd120);
        add_vec("andi x15,x6,5a5", 32'd120, enc_i(32'h5A5, 6, 3'd7, 15, 7'h13), 15, 32'h000005A5, 32'd124);
        add_vec("jalr x0,x0,-4",   32'd124, enc_i(-4, 0, 3'd0, 0, 7'h67),     0, 32'd0,        32'hFFFFFFFC);
        add_vec("addi x16 @wrap",  32'hFFFFFFFC, enc_i(7, 0, 3'd0, 16, 7'h13), 16, 32'd7,      32'd0);

        for (int i = 0; i < 256; i++) prog[i] = NOP;
        foreach (vecs[i]) prog[vecs[i].pc[9:2]] = vecs[i].ins;
        load_prog();

        // Reset state
        step();
        check("reset pc", mon.pc, 32'd0);
        for (int r = 1; r < 32; r++) check($sformatf("reset x%0d", r), dut_reg(r), 32'd0);
        $display("reset: pc=%08h", mon.pc);
        reset = 1'b1;

        foreach (vecs[i]) begin
            check($sformatf("%s pc_before", vecs[i].name), mon.pc, vecs[i].pc);
            step();
            check($sformatf("%s x%0d", vecs[i].name, vecs[i].rd), dut_reg(vecs[i].rd), vecs[i].val);
            check($sformatf("%s next_pc", vecs[i].name), mon.pc, vecs[i].npc);
            $display("vec %0d %s: pc=%08h x%0d=%08h", i, vecs[i].name, mon.pc,
                     vecs[i].rd, dut_reg(vecs[i].rd));
        end

        // Mid-program reset after the program has rewritten x1/x5.
        step();
        step();
        check("pre-reset x1", dut_reg(1), 32'd8);
        reset = 1'b0;
        step();
        check("mid reset pc", mon.pc, 32'd0);
        for (int r = 1; r < 32; r++) check($sformatf("mid reset x%0d", r), dut_reg(r), 32'd0);
        for (int i = 0; i < 256; i++)
            check($sformatf("rom word %0d kept", i), dut.cpu.program_memory[i], prog[i]);
        reset = 1'b1;
        step();
        check("post reset x5", dut_reg(5), 32'd100);
        check("post reset pc", mon.pc, 32'd4);
        $display("mid-program reset: pc=%08h x5=%08h", mon.pc, dut_reg(5));

        // Random programs vs. reference model.
        for (int p = 0; p < 4; p++) begin
            int cyc;
            reset = 1'b0;
            for (int i = 0; i < 256; i++) prog[i] = rand_instr();
            load_prog();
            step();
            m_pc = 32'd0;
            for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
            reset = 1'b1;
            bad0 = n_bad;
            cyc  = 0;
            for (int c = 0; c < 250 && n_bad == bad0; c++) begin
                model_step(wr_rd);
                step();
                check($sformatf("rand%0d cyc%0d pc", p, c), mon.pc, m_pc);
                if (wr_rd != 0)
                    check($sformatf("rand%0d cyc%0d x%0d", p, c, wr_rd), dut_reg(wr_rd), m_regs[wr_rd]);
                cyc++;
            end
            for (int r = 0; r < 32; r++)
                check($sformatf("rand%0d final x%0d", p, r), dut_reg(r), m_regs[r]);
            $display("random program %0d: %0d cycles, final pc=%08h", p, cyc, mon.pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
